// File: rtl/mem_write_checker.sv
// Self-check monitor for the single-cycle processor: watches data-memory stores
// and reports pass / fail / timeout with sticky status and captured failure info.
module mem_write_checker #(
  parameter int WIDTH       = 32,
  parameter int PASS_ADDR   = 100,
  parameter int PASS_DATA   = 7,
  parameter int IGNORE_ADDR = 96,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] write_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] PASS_A = WIDTH'(PASS_ADDR);
  localparam logic [WIDTH-1:0] PASS_D = WIDTH'(PASS_DATA);
  localparam logic [WIDTH-1:0] IGN_A  = WIDTH'(IGNORE_ADDR);
  localparam logic [63:0]      LAST_CYCLE = 64'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cycle_count, w_cycle_nxt;
  logic [CNT_W-1:0] r_write_count, w_write_nxt;
  logic [WIDTH-1:0] r_fail_addr, w_faddr_nxt;
  logic [WIDTH-1:0] r_fail_data, w_fdata_nxt;

  logic w_pass_hit;
  logic w_ign_hit;
  logic w_bad_hit;
  logic w_at_limit;

  // The pass check is evaluated first so PASS_ADDR==IGNORE_ADDR still passes.
  assign w_pass_hit = MemWrite && (DataAdr == PASS_A) && (WriteData == PASS_D);
  assign w_ign_hit  = MemWrite && !w_pass_hit && (DataAdr == IGN_A);
  assign w_bad_hit  = MemWrite && !w_pass_hit && !w_ign_hit;
  assign w_at_limit = (64'(r_cycle_count) == LAST_CYCLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cycle_nxt = r_cycle_count;
    w_write_nxt = r_write_count;
    w_faddr_nxt = r_fail_addr;
    w_fdata_nxt = r_fail_data;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_cycle_nxt = '0;
      w_write_nxt = '0;
      w_faddr_nxt = '0;
      w_fdata_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_cycle_nxt = '0;
            w_write_nxt = '0;
          end
        end
        S_RUN: begin
          if (w_pass_hit) begin
            w_state_nxt = S_PASS;
          end else if (w_bad_hit) begin
            w_state_nxt = S_FAIL;
            w_faddr_nxt = DataAdr;
            w_fdata_nxt = WriteData;
          end else begin
            if (w_ign_hit && !(&r_write_count))
              w_write_nxt = r_write_count + 1'b1;
            // Counter freezes at TIMEOUT-1 once the timeout is taken.
            if (w_at_limit)
              w_state_nxt = S_TOUT;
            else if (!(&r_cycle_count))
              w_cycle_nxt = r_cycle_count + 1'b1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cycle_count <= '0;
      r_write_count <= '0;
      r_fail_addr   <= '0;
      r_fail_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cycle_count <= w_cycle_nxt;
      r_write_count <= w_write_nxt;
      r_fail_addr   <= w_faddr_nxt;
      r_fail_data   <= w_fdata_nxt;
    end
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    pass   = 1'b0;
    fail   = 1'b0;
    status = 2'd0;
    case (r_state)
      S_RUN:  busy = 1'b1;
      S_PASS: begin done = 1'b1; pass = 1'b1; status = 2'd1; end
      S_FAIL: begin done = 1'b1; fail = 1'b1; status = 2'd2; end
      S_TOUT: begin done = 1'b1; fail = 1'b1; status = 2'd3; end
      default: status = 2'd0;
    endcase
  end

  assign cycle_count = r_cycle_count;
  assign write_count = r_write_count;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with a short timeout.
module tb_mem_write_checker;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             clear;
  logic             MemWrite;
  logic [WIDTH-1:0] DataAdr;
  logic [WIDTH-1:0] WriteData;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] write_count;
  logic [WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0] fail_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_write_checker #(
    .WIDTH(WIDTH), .PASS_ADDR(100), .PASS_DATA(7), .IGNORE_ADDR(96),
    .TIMEOUT(20), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .status(status),
    .cycle_count(cycle_count), .write_count(write_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    tick(2);
    chk("rst_status", 32'(status), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cycle", 32'(cycle_count), 0);
    chk("rst_wcnt", 32'(write_count), 0);
    chk("rst_faddr", fail_addr, 0);
    reset = 1'b1;
    tick();

    // pass sequence with two tolerated writes
    pulse_start();
    chk("run_busy", 32'(busy), 1);
    chk("run_cycle0", 32'(cycle_count), 0);
    do_write(96, 3);
    do_write(96, 5);
    chk("ign_wcnt", 32'(write_count), 2);
    chk("ign_cycle", 32'(cycle_count), 2);
    chk("ign_status", 32'(status), 0);
    do_write(100, 7);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_status", 32'(status), 1);
    chk("pass_wcnt", 32'(write_count), 2);
    chk("pass_fail", 32'(fail), 0);
    chk("pass_done", 32'(done), 1);
    chk("pass_busy", 32'(busy), 0);
    chk("pass_cycle_frozen", 32'(cycle_count), 2);
    do_write(104, 1);
    chk("pass_sticky", 32'(status), 1);

    pulse_clear();
    chk("clr_status", 32'(status), 0);
    chk("clr_cycle", 32'(cycle_count), 0);
    chk("clr_wcnt", 32'(write_count), 0);

    // bad address
    pulse_start();
    do_write(104, 7);
    chk("badadr_status", 32'(status), 2);
    chk("badadr_fail", 32'(fail), 1);
    chk("badadr_pass", 32'(pass), 0);
    chk("badadr_faddr", fail_addr, 104);
    chk("badadr_fdata", fail_data, 7);
    chk("badadr_cycle", 32'(cycle_count), 0);
    do_write(100, 7);
    chk("fail_sticky_wr", 32'(status), 2);
    pulse_start();
    chk("fail_sticky_start", 32'(status), 2);
    chk("fail_sticky_faddr", fail_addr, 104);

    // pass address, wrong data
    pulse_clear();
    chk("clr_faddr", fail_addr, 0);
    pulse_start();
    do_write(100, 8);
    chk("baddat_status", 32'(status), 2);
    chk("baddat_faddr", fail_addr, 100);
    chk("baddat_fdata", fail_data, 8);

    // timeout with a start pulse mid-run
    pulse_clear();
    pulse_start();
    tick(5);
    chk("to_cycle5", 32'(cycle_count), 5);
    pulse_start();
    chk("to_start_ignored", 32'(cycle_count), 6);
    tick(13);
    chk("to_cycle19", 32'(cycle_count), 19);
    chk("to_still_run", 32'(busy), 1);
    tick();
    chk("to_status", 32'(status), 3);
    chk("to_cycle_frozen", 32'(cycle_count), 19);
    chk("to_done", 32'(done), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_fail", 32'(fail), 1);

    // pass on the timeout edge wins
    pulse_clear();
    pulse_start();
    tick(19);
    do_write(100, 7);
    chk("edge_pass_status", 32'(status), 1);
    chk("edge_pass_pass", 32'(pass), 1);

    // writes in IDLE ignored
    pulse_clear();
    do_write(104, 7);
    chk("idle_wr_status", 32'(status), 0);
    chk("idle_wr_busy", 32'(busy), 0);
    chk("idle_wr_faddr", fail_addr, 0);

    // asynchronous reset mid-run
    pulse_start();
    tick(3);
    chk("pre_rst_cycle", 32'(cycle_count), 3);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_cycle", 32'(cycle_count), 0);
    chk("async_status", 32'(status), 0);
    tick();
    reset = 1'b1;
    tick(3);
    chk("no_rearm_busy", 32'(busy), 0);
    chk("no_rearm_cycle", 32'(cycle_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesisable, parametrised self-check monitor for the single-cycle processor top.
- Snoops the data-memory write port (MemWrite, DataAdr, WriteData) and decides pass/fail/timeout in hardware instead of in a bench process.
- Adds configurable signature address/value, a tolerated scratch address, a cycle timeout, sticky status and captured failure info.
- Instantiated beside the processor top in simulation and FPGA bring-up builds; status drives LEDs or bench checks.

Parameters:
- WIDTH, 32, width of DataAdr and WriteData.
- PASS_ADDR, 100, address whose write with PASS_DATA signals success.
- PASS_DATA, 7, value required at PASS_ADDR.
- IGNORE_ADDR, 96, scratch address whose writes are tolerated and counted.
- TIMEOUT, 1000, RUN cycles allowed before timeout; must be ≥ 1.
- CNT_W, 16, width of cycle_count and write_count.

Ports:
- clk  in  1  processor clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  one-cycle pulse; arms the checker from IDLE.
- clear  in  1  synchronous; returns any state to IDLE and zeroes the counters and captures.
- MemWrite  in  1  processor data-memory write enable.
- DataAdr  in  WIDTH  processor data-memory address.
- WriteData  in  WIDTH  processor store data.
- busy  out  1  1 in RUN.
- done  out  1  1 in PASS, FAIL or TOUT.
- pass  out  1  1 in PASS.
- fail  out  1  1 in FAIL or TOUT.
- status  out  2  0 IDLE/RUN, 1 PASS, 2 FAIL, 3 TOUT.
- cycle_count  out  CNT_W  cycles spent in RUN, saturating.
- write_count  out  CNT_W  tolerated IGNORE_ADDR writes, saturating.
- fail_addr  out  WIDTH  DataAdr of the offending write.
- fail_data  out  WIDTH  WriteData of the offending write.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including counters and captures.
- States are IDLE, RUN, PASS, FAIL, TOUT. All outputs are registered or decoded from state.
- Transitions (evaluated each rising edge, first match wins):
  - clear=1 → IDLE; counters and captures zeroed. This applies in every state and overrides everything below.
  - IDLE:
    - start=1 → RUN; cycle_count and write_count zeroed.
    - MemWrite in IDLE is ignored.
  - RUN with MemWrite=1:
    - DataAdr==PASS_ADDR and WriteData==PASS_DATA → PASS.
    - Else DataAdr==IGNORE_ADDR → stay in RUN; write_count+1 (saturates at all-ones).
    - Else → FAIL; fail_addr/fail_data capture DataAdr/WriteData of that cycle.
    - A write to PASS_ADDR with wrong data is FAIL unless PASS_ADDR==IGNORE_ADDR, where the pass check still wins.
  - RUN with no qualifying write: cycle_count+1 (saturates). When cycle_count==TIMEOUT-1 on this edge → TOUT.
  - A terminal write in the same cycle as the timeout edge takes priority over TOUT.
  - PASS, FAIL, TOUT are sticky: no further writes or start pulses change state; only clear or reset leave them.
- Counter timing: cycle_count counts every RUN cycle, including the cycle of a tolerated write. It freezes on entry to a terminal state.
- Latency: the write is sampled on edge N; pass/fail/done are visible after edge N, i.e. one cycle after the write.
- start while in RUN: ignored, no counter restart.
- Reset asserted mid-RUN: immediate IDLE with all outputs 0. Releasing reset does not re-arm; start is required.
- Purely registered; no combinational path from inputs to outputs.

Test Plan:
- Reset 0 for 2 cycles, release, start, then MemWrite with (96,3),(96,5),(100,7) → pass=1 and status=1 one cycle after the third write; write_count=2; fail=0.
- Start, then MemWrite (104,7) → status=2, fail=1, fail_addr=104, fail_data=7. A later (100,7) leaves status=2.
- Start, then MemWrite (100,8) → FAIL with fail_addr=100, fail_data=8.
- TIMEOUT=20, start, no writes → TOUT exactly 20 cycles after start; cycle_count=19, done=1, pass=0. Repeat with (100,7) on cycle 20 → PASS, not TOUT.
- In PASS, pulse clear → status=0, counters 0. Start again, then assert reset=0 mid-RUN → outputs 0 asynchronously, before the next clk edge.
- MemWrite pulses before start and after FAIL → no state or counter change; start during RUN does not reset cycle_count.
